// File: rtl/rx_frame_buffer.sv
// Store-and-forward receive frame buffer: bytes are held until the frame's
// verdict arrives, then good frames stream out as valid/ready bytes with m_last.
module rx_frame_buffer #(
   parameter int DEPTH      = 2048,
   parameter int MAX_FRAMES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_vld,
   input  logic        in_eof_ok,
   input  logic        in_eof_err,
   output logic [7:0]  m_data,
   output logic        m_valid,
   output logic        m_last,
   input  logic        m_ready,
   output logic [15:0] frames_ok,
   output logic [15:0] frames_dropped,
   output logic        in_overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int QW = $clog2(MAX_FRAMES);

   logic [7:0]  mem [DEPTH];
   logic [15:0] len_q [MAX_FRAMES];

   logic [AW:0] wr_ptr;
   logic [AW:0] commit_ptr;
   logic [AW:0] rd_ptr;
   logic [15:0] byte_cnt;
   logic        ovf;
   logic [QW:0] lq_wr;
   logic [QW:0] lq_rd;
   logic [QW:0] held;
   logic        active;
   logic [15:0] remain;

   logic [AW:0] used;
   logic        full;
   logic        wr_en;
   logic [AW:0] wr_ptr_nxt;
   logic [15:0] cnt_nxt;
   logic        ovf_nxt;
   logic        eof;
   logic        frames_full;
   logic        commit;
   logic        drop;
   logic        lq_empty;
   logic        load;
   logic        take;
   logic        pop;
   logic [15:0] cur_len;
   logic        xfer_last;

   assign in_overflow = ovf;

   // Pointers never cross, so the wrap bit of (wr_ptr - rd_ptr) flags a full store.
   assign used       = wr_ptr - rd_ptr;
   assign full       = used[AW];
   assign wr_en      = in_vld & ~full;
   assign wr_ptr_nxt = wr_ptr + (AW+1)'(wr_en);
   assign cnt_nxt    = byte_cnt + 16'(wr_en);
   assign ovf_nxt    = ovf | (in_vld & full);

   // A same-cycle byte belongs to the frame before its verdict is applied.
   // held counts committed frames not yet fully handed over, including the one in readout.
   assign eof         = in_eof_ok | in_eof_err;
   assign frames_full = (held == (QW+1)'(MAX_FRAMES));
   assign commit      = in_eof_ok & ~in_eof_err & ~ovf_nxt & (cnt_nxt != 16'd0) & ~frames_full;
   assign drop        = eof & ~commit;

   // Output handshake: a byte moves when m_valid & m_ready at the clock edge;
   // while m_valid & ~m_ready, m_data and m_last stay frozen.
   assign lq_empty  = (lq_wr == lq_rd);
   assign load      = ~m_valid | m_ready;
   assign cur_len   = active ? remain : len_q[lq_rd[QW-1:0]];
   assign take      = load & (active | ~lq_empty);
   assign pop       = take & ~active;
   assign xfer_last = m_valid & m_ready & m_last;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr[AW-1:0]] <= in_data;
      if (commit)
         len_q[lq_wr[QW-1:0]] <= cnt_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr         <= '0;
         commit_ptr     <= '0;
         byte_cnt       <= '0;
         ovf            <= 1'b0;
         lq_wr          <= '0;
         frames_ok      <= '0;
         frames_dropped <= '0;
      end else begin
         if (drop)
            wr_ptr <= commit_ptr;
         else
            wr_ptr <= wr_ptr_nxt;
         if (commit) begin
            commit_ptr <= wr_ptr_nxt;
            lq_wr      <= lq_wr + 1'b1;
         end
         byte_cnt <= eof ? 16'd0 : cnt_nxt;
         ovf      <= eof ? 1'b0 : ovf_nxt;
         if (commit && frames_ok != 16'hFFFF)
            frames_ok <= frames_ok + 16'd1;
         if (drop && frames_dropped != 16'hFFFF)
            frames_dropped <= frames_dropped + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         held <= '0;
      else
         held <= held + (QW+1)'(commit) - (QW+1)'(xfer_last);
   end

   // Popping a length and loading its first byte happen together, which keeps
   // commit-to-valid latency short and lets frames stream back to back.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr  <= '0;
         lq_rd   <= '0;
         active  <= 1'b0;
         remain  <= '0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
         m_data  <= '0;
      end else if (take) begin
         m_valid <= 1'b1;
         m_data  <= mem[rd_ptr[AW-1:0]];
         m_last  <= (cur_len == 16'd1);
         rd_ptr  <= rd_ptr + 1'b1;
         remain  <= cur_len - 16'd1;
         active  <= (cur_len != 16'd1);
         if (pop)
            lq_rd <= lq_rd + 1'b1;
      end else if (load) begin
         m_valid <= 1'b0;
         m_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Scoreboard bench for rx_frame_buffer: expected bytes are queued when a frame
// that should commit is driven, and popped as the DUT hands bytes over.
module tb_rx_frame_buffer;
   localparam int DEPTH      = 64;
   localparam int MAX_FRAMES = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_data = '0;
   logic        in_vld = 1'b0;
   logic        in_eof_ok = 1'b0;
   logic        in_eof_err = 1'b0;
   logic        m_ready = 1'b0;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_last;
   logic [15:0] frames_ok;
   logic [15:0] frames_dropped;
   logic        in_overflow;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [8:0]  exp_q[$];
   int          exp_ok = 0;
   int          exp_drop = 0;
   int          beat_cnt = 0;
   int          last_cnt = 0;
   bit          mon_en = 1'b0;
   bit          rand_ready = 1'b0;
   bit          ready_fix = 1'b0;

   rx_frame_buffer #(.DEPTH(DEPTH), .MAX_FRAMES(MAX_FRAMES)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_data        (in_data),
      .in_vld         (in_vld),
      .in_eof_ok      (in_eof_ok),
      .in_eof_err     (in_eof_err),
      .m_data         (m_data),
      .m_valid        (m_valid),
      .m_last         (m_last),
      .m_ready        (m_ready),
      .frames_ok      (frames_ok),
      .frames_dropped (frames_dropped),
      .in_overflow    (in_overflow)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: time %0t reached without finishing, required completion", $time);
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
   end

   // output monitor
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = '0;
   logic       prev_last = 1'b0;
   logic [8:0] mon_exp;

   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_stall) begin
            check_val("stall_valid", m_valid, 1);
            check_val("stall_data", m_data, prev_data);
            check_val("stall_last", m_last, prev_last);
         end
         if (m_valid && m_ready) begin
            beat_cnt++;
            if (m_last) last_cnt++;
            check_val("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               mon_exp = exp_q.pop_front();
               check_val("beat_data", m_data, mon_exp[7:0]);
               check_val("beat_last", m_last, mon_exp[8]);
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // driver tasks
   task automatic drive_cycle(input logic vld, input logic [7:0] d, input logic ok, input logic err);
      in_vld     = vld;
      in_data    = d;
      in_eof_ok  = ok;
      in_eof_err = err;
      @(posedge clk);
      #1;
      in_vld     = 1'b0;
      in_eof_ok  = 1'b0;
      in_eof_err = 1'b0;
   endtask

   task automatic send_frame(input int len, input int first, input bit ok, input bit err,
                             input bit keep, input bit together, input bit gaps);
      logic [7:0] b[$];
      for (int i = 0; i < len; i++)
         b.push_back(first < 0 ? 8'($urandom_range(0, 255)) : 8'(first + i));
      if (keep)
         for (int i = 0; i < len; i++)
            exp_q.push_back({1'(i == len - 1), b[i]});
      for (int i = 0; i < len; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
         if (together && i == len - 1)
            drive_cycle(1'b1, b[i], ok, err);
         else
            drive_cycle(1'b1, b[i], 1'b0, 1'b0);
      end
      if (!together || len == 0) drive_cycle(1'b0, 8'h00, ok, err);
      if (keep) exp_ok++;
      else exp_drop++;
   endtask

   function automatic int pend_frames();
      int c = 0;
      foreach (exp_q[i]) if (exp_q[i][8]) c++;
      return c;
   endfunction

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val("drain", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_room(input int len);
      int n = 0;
      while (!((exp_q.size() + len <= DEPTH) && (pend_frames() < MAX_FRAMES)) && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val("room_wait", n < 5000, 1);
   endtask

   task automatic check_counts(input string tag);
      check_val({tag, "_frames_ok"}, frames_ok, exp_ok);
      check_val({tag, "_frames_dropped"}, frames_dropped, exp_drop);
   endtask

   initial begin
      int b0;
      int l0;
      int n;
      int len;
      bit ok;
      bit keep;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_val("rst_m_valid", m_valid, 0);
      check_val("rst_m_last", m_last, 0);
      check_val("rst_m_data", m_data, 0);
      check_val("rst_overflow", in_overflow, 0);
      check_counts("rst");
      mon_en = 1'b1;

      // 64-byte incrementing frame, consumer always ready
      ready_fix = 1'b1;
      l0 = last_cnt;
      send_frame(64, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_val("t1_latency_valid", m_valid, 1);
      wait_drain(500);
      check_val("t1_last_count", last_cnt - l0, 1);
      check_counts("t1");

      // error frame, empty commit, both-pulse frame, then a good frame
      send_frame(20, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      send_frame(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(6, 8'h30, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      send_frame(10, 8'hA0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      wait_drain(500);
      check_counts("t2");

      // overflow: 70 bytes into a 64-byte store with the consumer stalled
      ready_fix = 1'b0;
      for (int i = 0; i < 70; i++) begin
         drive_cycle(1'b1, 8'(i), 1'b0, 1'b0);
         if (i == 63) check_val("t3_ovf_at_64", in_overflow, 0);
         if (i == 64) check_val("t3_ovf_at_65", in_overflow, 1);
      end
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      exp_drop++;
      check_val("t3_ovf_cleared", in_overflow, 0);
      check_counts("t3");
      for (int i = 0; i < 4; i++) begin
         check_val("t3_no_valid", m_valid, 0);
         @(posedge clk);
         #1;
      end
      ready_fix = 1'b1;
      send_frame(8, 8'hC0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      wait_drain(500);
      check_counts("t3b");

      // frame-count limit: ninth held frame is dropped
      ready_fix = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int f = 0; f < MAX_FRAMES + 1; f++)
         send_frame(4, 16 * f, 1'b1, 1'b0, f < MAX_FRAMES, 1'b0, 1'b0);
      check_counts("t4");
      check_val("t4_queued", exp_q.size(), 4 * MAX_FRAMES);
      b0 = beat_cnt;
      l0 = last_cnt;
      ready_fix = 1'b1;
      wait_drain(500);
      check_val("t4_beats", beat_cnt - b0, 4 * MAX_FRAMES);
      check_val("t4_lasts", last_cnt - l0, MAX_FRAMES);

      // random traffic with a random consumer, wrapping many times
      rand_ready = 1'b1;
      for (int f = 0; f < 200; f++) begin
         len  = $urandom_range(1, 100);
         ok   = ($urandom_range(0, 9) != 0);
         keep = ok && (len <= DEPTH);
         if (keep) wait_room(len);
         send_frame(len, -1, ok, !ok, keep, 1'($urandom_range(0, 1)), 1'b1);
         repeat ($urandom_range(0, 2)) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
      end
      rand_ready = 1'b0;
      ready_fix  = 1'b1;
      wait_drain(5000);
      check_counts("t5");

      // reset in the middle of a frame readout
      b0 = beat_cnt;
      send_frame(40, 8'h40, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      n = 0;
      while (beat_cnt - b0 < 10 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val("t6_streaming", beat_cnt - b0 >= 10, 1);
      mon_en = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      check_val("t6_m_valid", m_valid, 0);
      check_val("t6_m_last", m_last, 0);
      exp_ok   = 0;
      exp_drop = 0;
      check_counts("t6_rst");
      rst = 1'b0;
      mon_en = 1'b1;
      send_frame(5, 8'h50, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      wait_drain(500);
      check_counts("t6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rx_frame_buffer.md
Name: rx_frame_buffer

Overview:
Store-and-forward frame buffer directly downstream of the Ethernet receive FSM. Accepts received bytes and an end-of-frame verdict. A frame is released to the consumer only after a good verdict; frames with an error verdict or an overflow are discarded in full. Output is a valid/ready byte stream with a last-byte flag, so consumers never see partial or corrupt frames.

Parameters:
DEPTH, 2048, data store size in bytes; power of two, >= 64.
MAX_FRAMES, 8, committed frames held simultaneously (length queue depth); power of two.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_data  in  8  received byte
in_vld  in  1  in_data belongs to the current frame this cycle
in_eof_ok  in  1  one-cycle pulse: current frame passed FCS, commit it
in_eof_err  in  1  one-cycle pulse: current frame failed, drop it
m_data  out  8  output byte
m_valid  out  1  m_data valid
m_last  out  1  m_data is the final byte of its frame
m_ready  in  1  consumer accepts m_data this cycle
frames_ok  out  16  committed-frame count, saturates at 16'hFFFF
frames_dropped  out  16  dropped-frame count, saturates at 16'hFFFF
in_overflow  out  1  current in-progress frame has overflowed (sticky until eof)

Behaviour:
- Reset: all pointers, counters and flags cleared. m_valid=0, m_last=0, m_data=0, frames_ok=0, frames_dropped=0, in_overflow=0. Reset mid-frame or mid-readout discards all stored data.
- Write side:
  - wr_ptr (speculative) and commit_ptr, both log2(DEPTH)+1 bits including a wrap bit.
  - In-frame byte count is 16 bits.
  - in_vld=1 and store not full (wr_ptr - rd_ptr < DEPTH): write in_data at wr_ptr, increment wr_ptr and the byte count.
  - in_vld=1 and store full: byte not written; in_overflow set.
- EOF handling:
  - in_vld may coincide with an eof pulse; that byte is part of the frame and is processed before the eof.
  - Both eof pulses in the same cycle: treated as eof_err.
  - Commit on eof_ok when all hold: overflow clear, length > 0, length queue not full. Push length onto the length queue, commit_ptr <= wr_ptr, frames_ok++.
  - Otherwise (eof_err or any commit condition fails): wr_ptr <= commit_ptr (rollback), frames_dropped++.
  - In all eof cases: length count and in_overflow cleared the next cycle.
- Read side:
  - Idle and length queue non-empty: pop length and begin streaming from rd_ptr.
  - m_valid rises no later than 2 cycles after the commit cycle when the buffer was idle.
  - A transfer occurs on m_valid & m_ready.
  - m_last=1 on the byte where remaining count reaches 1.
  - After the last transfer, the next frame's first byte may be presented the following cycle (no mandatory gap).
  - m_valid=1 & m_ready=0: m_data, m_last held stable.
  - rd_ptr never passes commit_ptr. Uncommitted bytes are never read.
- Free space is freed only as bytes are read (rd_ptr advances). A rollback reclaims only uncommitted space.
- Simultaneous write, commit and read in the same cycle are all legal and independent.
- Pointer wrap at DEPTH is seamless; frames may straddle the wrap.
- Counters saturate; no wrap.

Test Plan:
1. 64-byte frame 0x00..0x3F, then eof_ok, m_ready=1 -> 64 beats 0x00..0x3F in order, m_last only on 0x3F, frames_ok=1.
2. 20-byte frame with eof_err, then 10-byte frame 0xA0..0xA9 with eof_ok -> only 0xA0..0xA9 appear, frames_dropped=1, frames_ok=1.
3. DEPTH=64, m_ready=0, 70-byte frame with eof_ok -> in_overflow=1 after byte 64, frame dropped, m_valid stays 0, frames_dropped=1; a later 8-byte frame passes intact.
4. MAX_FRAMES+1 4-byte frames committed with m_ready=0 -> 9th dropped; on m_ready=1 exactly 8 frames (32 beats, 8 m_last) emerge.
5. Random m_ready (50%) over 200 frames of 1..100 bytes straddling the wrap -> output byte-exact against model, m_data stable while stalled.
6. Assert rst mid-stream of a 40-byte frame -> m_valid=0 next cycle, counters 0; a subsequent 5-byte frame is delivered correctly.
